// File: rtl/smp_div_pkg.sv
// Shared types and default widths for the smp_div restoring divider.
package smp_div_pkg;

   localparam int W_N_DEF = 17;
   localparam int W_D_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/smp_div_step.sv
// One combinational restoring-division step: shift a dividend bit into the
// partial remainder, subtract the divisor when it fits.
module smp_div_step #(
   parameter int W_D = 16
) (
   input  logic [W_D-1:0] rem,
   input  logic           dbit,
   input  logic [W_D-1:0] divisor,
   output logic [W_D-1:0] rem_next,
   output logic           qbit
);

   logic [W_D:0] partial;
   logic [W_D:0] diff;

   // rem < divisor on entry, so both candidates fit back into W_D bits.
   always_comb begin
      partial  = {rem, dbit};
      diff     = partial - {1'b0, divisor};
      qbit     = (partial >= {1'b0, divisor});
      rem_next = qbit ? W_D'(diff) : W_D'(partial);
   end

endmodule

// File: rtl/smp_div.sv
// Iterative unsigned divider, W_N-step restoring algorithm, MSB first.
// Define SMP_DIV_POW2_EN to resolve one-hot divisors on the accept edge.
module smp_div
   import smp_div_pkg::*;
#(
   parameter int W_N = W_N_DEF,
   parameter int W_D = W_D_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W_N-1:0] in1,
   input  logic [W_D-1:0] in2,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W_N-1:0] out1,
   output logic [W_D-1:0] out2,
   output logic           div0,
   output state_t         dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid and ready
   // are both high; ready never depends on valid on the same side.

   localparam int CW = $clog2(W_N + 1);

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt;
   logic [W_N-1:0] acc;
   logic [W_D-1:0] rem;
   logic [W_D-1:0] dvsr;
   logic [W_D-1:0] rem_next;
   logic           qbit;
   logic           accept;
   logic           last_step;
   logic           is_pow2;

`ifdef SMP_DIV_POW2_EN
   logic [W_N-1:0] pow2_q;
   logic [W_D-1:0] pow2_r;

   always_comb begin
      is_pow2 = (in2 != '0) && ((in2 & (in2 - 1'b1)) == '0);
      pow2_q  = in1;
      for (int i = 0; i < W_D; i++) begin
         if (in2[i]) pow2_q = in1 >> i;
      end
      pow2_r  = (in2 - 1'b1) & in1[W_D-1:0];
   end
`else
   assign is_pow2 = 1'b0;
`endif

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign dbg_state = state;
   assign accept    = in_ready && in_valid;
   assign last_step = (cnt == CW'(1));

   smp_div_step #(.W_D(W_D)) u_step (
      .rem      (rem),
      .dbit     (acc[W_N-1]),
      .divisor  (dvsr),
      .rem_next (rem_next),
      .qbit     (qbit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (in2 == '0 || is_pow2) state_nxt = DONE;
               else                      state_nxt = RUN;
            end
         end
         RUN:     if (last_step) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // acc shifts dividend bits out of the top and quotient bits in at the bottom.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         acc  <= '0;
         rem  <= '0;
         dvsr <= '0;
         out1 <= '0;
         out2 <= '0;
         div0 <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (in2 == '0) begin
                     out1 <= '1;
                     out2 <= '0;
                     div0 <= 1'b1;
`ifdef SMP_DIV_POW2_EN
                  end else if (is_pow2) begin
                     out1 <= pow2_q;
                     out2 <= pow2_r;
                     div0 <= 1'b0;
`endif
                  end else begin
                     acc  <= in1;
                     rem  <= '0;
                     dvsr <= in2;
                     cnt  <= CW'(W_N);
                  end
               end
            end
            RUN: begin
               acc <= W_N'({acc, qbit});
               rem <= rem_next;
               cnt <= cnt - 1'b1;
               if (last_step) begin
                  out1 <= W_N'({acc, qbit});
                  out2 <= rem_next;
                  div0 <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_smp_div.sv
// Self-checking bench for smp_div: directed and random divisions against a
// reference model, latency, hold, handshake and mid-operation reset.
module tb_smp_div;
   import smp_div_pkg::*;

   localparam int W_N = 17;
   localparam int W_D = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [W_N-1:0] in1;
   logic [W_D-1:0] in2;
   logic           out_valid;
   logic           out_ready;
   logic [W_N-1:0] out1;
   logic [W_D-1:0] out2;
   logic           div0;
   state_t         dbg_state;

   int n_vec = 0;
   int n_bad = 0;

   logic [W_N-1:0] exp_q1[$];
   logic [W_D-1:0] exp_q2[$];
   logic           exp_qz[$];
   int             exp_ql[$];

   smp_div #(.W_N(W_N), .W_D(W_D)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out1      (out1),
      .out2      (out2),
      .div0      (div0),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Latency = rising edges after the accept edge until out_valid is seen;
   // immediate paths complete on the accept edge itself (0).
   task automatic push_exp(input logic [W_N-1:0] a, input logic [W_D-1:0] b);
      bit p2;
      p2 = (b != 0) && ((b & (b - 1'b1)) == 0);
      if (b == 0) begin
         exp_q1.push_back('1);
         exp_q2.push_back('0);
         exp_qz.push_back(1'b1);
         exp_ql.push_back(0);
      end else begin
         exp_q1.push_back(a / b);
         exp_q2.push_back(W_D'(a % b));
         exp_qz.push_back(1'b0);
`ifdef SMP_DIV_POW2_EN
         exp_ql.push_back(p2 ? 0 : W_N);
`else
         exp_ql.push_back(p2 ? W_N : W_N);
`endif
      end
   endtask

   task automatic run_op(input logic [W_N-1:0] a, input logic [W_D-1:0] b, input int hold);
      int lat;
      logic [W_N-1:0] e1;
      logic [W_D-1:0] e2;
      logic           ez;
      int             el;
      push_exp(a, b);
      @(negedge clk);
      in1 = a;
      in2 = b;
      in_valid = 1'b1;
      check("in_ready_idle", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in1 = W_N'($urandom);
      in2 = W_D'($urandom);
      lat = 0;
      while (!out_valid && lat < 200) begin
         out_ready = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         lat++;
      end
      out_ready = 1'b0;
      e1 = exp_q1.pop_front();
      e2 = exp_q2.pop_front();
      ez = exp_qz.pop_front();
      el = exp_ql.pop_front();
      check("out_valid_seen", out_valid, 1);
      check("latency", lat, el);
      check("quotient", out1, e1);
      check("remainder", out2, e2);
      check("div0", div0, ez);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check("hold_valid", out_valid, 1);
         check("hold_in_ready", in_ready, 0);
         check("hold_q", out1, e1);
         check("hold_r", out2, e2);
         check("hold_div0", div0, ez);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("release_valid", out_valid, 0);
      check("release_in_ready", in_ready, 1);
      check("keep_q", out1, e1);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in1 = '0;
      in2 = '0;
      out_ready = 1'b0;
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out1", out1, 0);
      check("rst_out2", out2, 0);
      check("rst_div0", div0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_op(17'd100, 16'd7, 0);
      run_op(17'd131071, 16'd1, 1);
      run_op(17'd5, 16'd65535, 0);
      run_op(17'd5, 16'd0, 2);
      run_op(17'd96, 16'd8, 0);
      run_op(17'd0, 16'd3, 0);
      run_op(17'd131071, 16'd65535, 0);
      run_op(17'd131071, 16'd32768, 10);

      // Reset in the middle of an iterative operation.
      push_exp(17'd1000, 16'd3);
      @(negedge clk);
      in1 = 17'd1000;
      in2 = 16'd3;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_out1", out1, 0);
      check("midrst_out2", out2, 0);
      void'(exp_q1.pop_front());
      void'(exp_q2.pop_front());
      void'(exp_qz.pop_front());
      void'(exp_ql.pop_front());
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_no_valid", out_valid, 0);
      run_op(17'd9, 16'd4, 0);

      for (int k = 0; k < 8; k++) begin
         run_op(W_N'($urandom_range(0, 131071)), W_D'($urandom_range(1, 65535)),
                $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
